// File: rtl/uart_pkg.sv
// Shared definitions for the debug UART receive and transmit wrappers.
//   - rx_state_e  : bit-level receiver FSM states
//   - G_UART_IWS  : UART character width (bits per frame payload)
//   - thold_width : width of the AXIS thold field for a given tdata width
package uart_pkg;

  localparam int G_UART_IWS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // thold encodes "k valid low bytes", so it needs room for 1..N-1.
  function automatic int thold_width(input int tdata_size);
    return (tdata_size / 8 > 2) ? $clog2(tdata_size / 8) : 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchronizer plus bit-level FSM.
// Ports:
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_rxd           : raw serial input, idle high
//   o_byte          : last received byte (valid when o_strobe is high)
//   o_strobe        : 1-cycle pulse, byte received with a good stop bit
//   o_frame_err     : 1-cycle pulse, stop bit sampled low
//   o_busy          : FSM not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_rxd,
  output logic [G_UART_IWS-1:0] o_byte,
  output logic                  o_strobe,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(G_UART_IWS);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(G_UART_IWS - 1);

  logic [1:0]            sync_q;
  logic                  rxd_s;
  rx_state_e             state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [G_UART_IWS-1:0] shreg_q, shreg_d;
  logic                  strobe_q, strobe_d;
  logic                  ferr_q, ferr_d;

  assign rxd_s = sync_q[1];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync_q    <= 2'b11;
      state_q   <= RX_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      strobe_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_rxd};
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      strobe_q  <= strobe_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    strobe_d  = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          state_d   = RX_START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      RX_START: begin
        // Re-check half a bit in: a line that is already high again was a glitch.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          state_d   = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shreg_d   = {rxd_s, shreg_q[G_UART_IWS-1:1]};
          if (bit_cnt_q == LAST_BIT) state_d = RX_STOP;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rxd_s) begin
            strobe_d = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        // A held-low line must go high before another start bit is accepted.
        if (rxd_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_byte      = shreg_q;
  assign o_strobe    = strobe_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_rx_packer.sv
// Debug UART receive path: serial 8N1 receiver feeding a byte packer that
// emits G_AXIS_TDATA_SIZE-bit AXIS words, first byte in [7:0]. A partial
// word is flushed after an idle-line timeout with thold = number of bytes.
// Ports:
//   i_clk, i_arst_n   : clock, asynchronous active-low reset
//   i_rxd             : serial input, idle high
//   i_m_axis_tready   : sink ready
//   o_m_axis_tvalid/tdata/thold : AXIS word (thold 0 = all bytes valid)
//   o_rxd_busy        : receiver mid-frame
//   o_rx_frame_err    : 1-cycle pulse, bad stop bit
//   o_rx_overrun      : 1-cycle pulse, received byte dropped
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT        = 16,
  parameter int G_AXIS_TDATA_SIZE   = 32,
  parameter int G_AXIS_THOLD_SIZE   = thold_width(G_AXIS_TDATA_SIZE),
  parameter int G_IDLE_TIMEOUT_BITS = 20
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic                         i_rxd,
  input  logic                         i_m_axis_tready,
  output logic                         o_m_axis_tvalid,
  output logic [G_AXIS_TDATA_SIZE-1:0] o_m_axis_tdata,
  output logic [G_AXIS_THOLD_SIZE-1:0] o_m_axis_thold,
  output logic                         o_rxd_busy,
  output logic                         o_rx_frame_err,
  output logic                         o_rx_overrun
);

  localparam int N      = G_AXIS_TDATA_SIZE / 8;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int TO_MAX = G_IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_MAX + 1);

  logic [G_UART_IWS-1:0]        rx_byte;
  logic                         rx_strobe, rx_ferr, rx_busy;

  logic [CNT_W-1:0]             cnt_q, cnt_d, wr_cnt;
  logic [G_AXIS_TDATA_SIZE-1:0] pack_q, pack_d, wr_data, nxt;
  logic [TO_W-1:0]              to_q, to_d;
  logic                         tvalid_q, tvalid_d;
  logic [G_AXIS_TDATA_SIZE-1:0] tdata_q, tdata_d;
  logic [G_AXIS_THOLD_SIZE-1:0] thold_q, thold_d;
  logic                         ovr_q, ovr_d;
  logic                         out_free, full, to_hit, loaded;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk       (i_clk),
    .i_arst_n    (i_arst_n),
    .i_rxd       (i_rxd),
    .o_byte      (rx_byte),
    .o_strobe    (rx_strobe),
    .o_frame_err (rx_ferr),
    .o_busy      (rx_busy)
  );

  assign out_free = !tvalid_q || i_m_axis_tready;
  assign full     = (cnt_q == CNT_W'(N));
  assign to_hit   = (to_q == TO_W'(TO_MAX));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q    <= '0;
      pack_q   <= '0;
      to_q     <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      thold_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      to_q     <= to_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      thold_q  <= thold_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    pack_d   = pack_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    thold_d  = thold_q;
    ovr_d    = 1'b0;
    loaded   = 1'b0;
    wr_cnt   = cnt_q;
    wr_data  = pack_q;
    nxt      = '0;

    if (tvalid_q && i_m_axis_tready) tvalid_d = 1'b0;

    // Idle timer runs only while the line is idle and a partial word waits;
    // it saturates so a flush blocked by a busy output register still happens.
    if (rx_busy || cnt_q == '0 || full) to_d = '0;
    else if (!to_hit)                    to_d = to_q + 1'b1;
    else                                 to_d = to_q;

    // Move a pending full word, or flush a timed-out partial word.
    if (full) begin
      if (out_free) begin
        tvalid_d = 1'b1;
        tdata_d  = pack_q;
        thold_d  = '0;
        loaded   = 1'b1;
      end
    end else if (cnt_q != '0 && to_hit && out_free) begin
      tvalid_d = 1'b1;
      tdata_d  = pack_q;
      thold_d  = G_AXIS_THOLD_SIZE'(cnt_q);
      loaded   = 1'b1;
      to_d     = '0;
    end
    if (loaded) begin
      wr_cnt  = '0;
      wr_data = '0;
      cnt_d   = '0;
      pack_d  = '0;
    end

    // Incoming byte lands in the packer as it looks after any transfer above.
    if (rx_strobe) begin
      if (full && !out_free) begin
        ovr_d = 1'b1;
      end else begin
        nxt = wr_data;
        for (int i = 0; i < N; i++) begin
          if (wr_cnt == CNT_W'(i)) nxt[8*i +: 8] = rx_byte;
        end
        // Completing a word with a free output register skips the pending
        // state so tvalid follows the last byte by one cycle.
        if (wr_cnt == CNT_W'(N - 1) && out_free && !loaded) begin
          tvalid_d = 1'b1;
          tdata_d  = nxt;
          thold_d  = '0;
          cnt_d    = '0;
          pack_d   = '0;
        end else begin
          cnt_d  = wr_cnt + 1'b1;
          pack_d = nxt;
        end
      end
    end
  end

  assign o_m_axis_tvalid = tvalid_q;
  assign o_m_axis_tdata  = tdata_q;
  assign o_m_axis_thold  = thold_q;
  assign o_rxd_busy      = rx_busy;
  assign o_rx_frame_err  = rx_ferr;
  assign o_rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
module tb_uart_rx_packer;

  localparam int CPB = 16;
  localparam int W   = 32;
  localparam int TH  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic          tready;
  logic          tvalid;
  logic [W-1:0]  tdata;
  logic [TH-1:0] thold;
  logic          busy, ferr, ovr;

  always #5 clk = ~clk;

  uart_rx_packer #(
    .CLKS_PER_BIT        (CPB),
    .G_AXIS_TDATA_SIZE   (W),
    .G_AXIS_THOLD_SIZE   (TH),
    .G_IDLE_TIMEOUT_BITS (20)
  ) dut (
    .i_clk           (clk),
    .i_arst_n        (rst_n),
    .i_rxd           (rxd),
    .i_m_axis_tready (tready),
    .o_m_axis_tvalid (tvalid),
    .o_m_axis_tdata  (tdata),
    .o_m_axis_thold  (thold),
    .o_rxd_busy      (busy),
    .o_rx_frame_err  (ferr),
    .o_rx_overrun    (ovr)
  );

  typedef struct {
    logic [W-1:0]  d;
    logic [TH-1:0] h;
  } exp_t;

  typedef struct {
    int            n;
    logic [W-1:0]  bytes;
    logic [W-1:0]  d;
    logic [TH-1:0] h;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[5];

  int n_tests = 0;
  int n_fail  = 0;
  int strb_cnt = 0;
  int fe_cnt   = 0;
  int ovr_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic [TH-1:0] h);
    exp_t e;
    e.d = d;
    e.h = h;
    sbq.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] b);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    logic          got;
    logic          seen;
    int            s0, f0, o0;
    logic [W-1:0]  tmp;

    vecs[0] = '{4, 32'hDEADBEEF, 32'hDEADBEEF, 2'd0};
    vecs[1] = '{3, 32'h00030201, 32'h00030201, 2'd3};
    vecs[2] = '{1, 32'h000000C3, 32'h000000C3, 2'd1};
    vecs[3] = '{4, 32'h0180FF00, 32'h0180FF00, 2'd0};
    vecs[4] = '{2, 32'h00007F80, 32'h00007F80, 2'd2};

    rxd    = 1'b1;
    tready = 1'b1;
    rst_n  = 1'b0;

    // Output monitor: pulse counters, AXIS stability and scoreboard pops.
    fork
      begin
        logic          hold_prev;
        logic [W-1:0]  prev_d;
        logic [TH-1:0] prev_h;
        exp_t          e;
        hold_prev = 1'b0;
        prev_d    = '0;
        prev_h    = '0;
        forever begin
          @(negedge clk);
          #1;
          if (dut.rx_strobe) strb_cnt++;
          if (ferr) fe_cnt++;
          if (ovr)  ovr_cnt++;
          if (rst_n) begin
            if (hold_prev) begin
              chk("axis_hold_valid", 64'(tvalid), 64'd1);
              chk("axis_hold_data", 64'({tdata, thold}), 64'({prev_d, prev_h}));
            end
            if (tvalid && tready) begin
              if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h thold %0h, none expected", tdata, thold);
              end else begin
                e = sbq.pop_front();
                chk("word_data", 64'(tdata), 64'(e.d));
                chk("word_thold", 64'(thold), 64'(e.h));
              end
            end
            hold_prev = tvalid && !tready;
            prev_d    = tdata;
            prev_h    = thold;
          end else begin
            hold_prev = 1'b0;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_thold", 64'(thold), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ferr", 64'(ferr), 64'd0);
    chk("rst_ovr", 64'(ovr), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Full word, tvalid exactly one cycle after the 4th strobe.
    push(32'h44332211, 2'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_bits(8'h44);
    rxd = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 2 * CPB; k++) begin
      @(negedge clk);
      if (dut.rx_strobe) begin
        got = 1'b1;
        break;
      end
    end
    chk("lat_strobe_seen", 64'(got), 64'd1);
    chk("lat_no_early_valid", 64'(tvalid), 64'd0);
    @(negedge clk);
    chk("lat_tvalid", 64'(tvalid), 64'd1);
    chk("lat_tdata", 64'(tdata), 64'h44332211);
    repeat (CPB) @(negedge clk);
    wait_drain(20);

    // Partial word flushed after the idle timeout, not before.
    push(32'h00005AA5, 2'd2);
    send_byte(8'hA5);
    send_byte(8'h5A);
    seen = 1'b0;
    for (int k = 0; k < 290; k++) begin
      @(negedge clk);
      if (tvalid) seen = 1'b1;
    end
    chk("idle_no_early_flush", 64'(seen), 64'd0);
    wait_drain(100);

    // Table-driven words, full and partial.
    for (int v = 0; v < 5; v++) begin
      push(vecs[v].d, vecs[v].h);
      for (int b = 0; b < vecs[v].n; b++) begin
        tmp = vecs[v].bytes >> (8 * b);
        send_byte(tmp[7:0]);
      end
      wait_drain(600);
    end

    // Short low glitch is rejected.
    s0 = strb_cnt;
    f0 = fe_cnt;
    seen = 1'b0;
    rxd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    rxd = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", 64'(seen), 64'd1);
    chk("glitch_busy_end", 64'(busy), 64'd0);
    chk("glitch_no_strobe", 64'(strb_cnt), 64'(s0));
    chk("glitch_no_ferr", 64'(fe_cnt), 64'(f0));
    chk("glitch_no_word", 64'(tvalid), 64'd0);

    // Stop bit low, line held low: one frame error, then no frames.
    s0 = strb_cnt;
    f0 = fe_cnt;
    send_bits(8'h7E);
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    chk("ferr_one_pulse", 64'(fe_cnt), 64'(f0 + 1));
    chk("ferr_no_strobe", 64'(strb_cnt), 64'(s0));
    chk("ferr_busy_in_break", 64'(busy), 64'd1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_busy_released", 64'(busy), 64'd0);
    chk("ferr_still_one", 64'(fe_cnt), 64'(f0 + 1));
    chk("ferr_still_no_strobe", 64'(strb_cnt), 64'(s0));
    chk("ferr_no_word", 64'(tvalid), 64'd0);

    // Back-pressure: 9 bytes, second word pending, 9th byte overruns.
    o0 = ovr_cnt;
    tready = 1'b0;
    push(32'h04030201, 2'd0);
    push(32'h08070605, 2'd0);
    for (int b = 1; b <= 9; b++) send_byte(8'(b));
    chk("ovr_pulse", 64'(ovr_cnt), 64'(o0 + 1));
    chk("ovr_tvalid_held", 64'(tvalid), 64'd1);
    chk("ovr_first_word_held", 64'(tdata), 64'h04030201);
    tready = 1'b1;
    wait_drain(50);
    repeat (2) @(negedge clk);
    chk("ovr_drained_tvalid", 64'(tvalid), 64'd0);

    // Reset mid-frame after two packed bytes discards everything.
    send_byte(8'h10);
    send_byte(8'h20);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("rstmid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", 64'(tvalid), 64'd0);
    chk("rstmid_tdata", 64'(tdata), 64'd0);
    chk("rstmid_thold", 64'(thold), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_pulses", 64'({ferr, ovr}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push(32'h8899AABB, 2'd0);
    send_byte(8'hBB);
    send_byte(8'hAA);
    send_byte(8'h99);
    send_byte(8'h88);
    wait_drain(40);
    repeat (10) @(negedge clk);
    chk("final_idle_tvalid", 64'(tvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_packer.md
Name: uart_rx_packer

Overview:
- Receive direction of the debug UART: a serial 8N1 receiver plus a byte packer that assembles received bytes into G_AXIS_TDATA_SIZE-bit AXIS words, first byte in [7:0].
- A partial word is flushed after an idle-line timeout. Flushed words carry the same thold encoding the TX path consumes, so host words loop back byte-exact.
- Sits between the external RXD pin and an AXIS sink, either a FIFO or a register bank.

Parameters:
- CLKS_PER_BIT, 16, i_clk cycles per UART bit; must be >= 4 and even.
- G_AXIS_TDATA_SIZE, 32, output word width; must be a multiple of 8 and >= 8.
- G_AXIS_THOLD_SIZE, (G_AXIS_TDATA_SIZE/8 > 2) ? $clog2(G_AXIS_TDATA_SIZE/8) : 1, thold width.
- G_IDLE_TIMEOUT_BITS, 20, idle bit-times before a partial word is flushed.

Ports:
- i_clk  in  1  single clock.
- i_arst_n  in  1  reset, asynchronous, active-low.
- i_rxd  in  1  serial input, asynchronous to i_clk, idle high.
- i_m_axis_tready  in  1  sink ready.
- o_m_axis_tvalid  out  1  word valid.
- o_m_axis_tdata  out  G_AXIS_TDATA_SIZE  packed bytes.
- o_m_axis_thold  out  G_AXIS_THOLD_SIZE  0 = all bytes valid; k = only [8k-1:0] valid.
- o_rxd_busy  out  1  receiver FSM not in IDLE.
- o_rx_frame_err  out  1  1-cycle pulse: stop bit sampled low.
- o_rx_overrun  out  1  1-cycle pulse: received byte dropped.

Behaviour:
- Reset values: tvalid=0, tdata=0, thold=0, busy=0, both pulses 0. Synchronizer flops reset to 1.
- Reset asserted mid-frame or mid-word discards everything; the FSM returns to IDLE.
- i_rxd passes through a 2-FF synchronizer. All decisions use the synced value.
- FSM states IDLE, START, DATA, STOP, BREAK:
  - IDLE: synced rxd=0 -> START, bit counter cleared.
  - START: at cycle CLKS_PER_BIT/2-1, sample. 0 -> DATA. 1 -> IDLE (glitch rejected, no pulse).
  - DATA: sample every CLKS_PER_BIT cycles at bit centre, LSB first. After the 8th bit -> STOP.
  - STOP: sample at centre. 1 -> byte strobe (1 cycle), then IDLE. 0 -> o_rx_frame_err pulse, byte discarded, then BREAK.
  - BREAK: wait for synced rxd=1 -> IDLE. This prevents a held-low line from spawning frames.
- Packer holds lane count c (0..N, N=G_AXIS_TDATA_SIZE/8). Each byte strobe writes lane c and increments c. Unused lanes are zero.
- c==N: the word becomes pending and moves to the output register on the first cycle the register is empty or handshaking (tvalid & tready). It moves with thold=0 and c resets to 0.
- Latency: with the output register free, tvalid asserts the cycle after the final byte strobe.
- Idle timeout: counts cycles while FSM==IDLE and 0<c<N; clears on any start detect.
  - At G_IDLE_TIMEOUT_BITS*CLKS_PER_BIT the partial word transfers like a full word, with thold=c.
  - If the output register is busy, the counter saturates and the flush waits.
- Output register follows AXIS rules: tdata and thold are stable while tvalid & !tready. A new word may load in the same cycle as a handshake, giving back-to-back words.
- Byte strobe while the packer holds a pending full word that cannot transfer this cycle: byte dropped, o_rx_overrun pulses, pending word unchanged.
- Byte strobe in the same cycle as a pending-word transfer: the byte is accepted into lane 0 of the emptied packer.
- Byte strobe in the same cycle as a timeout flush: the flush takes the old c bytes and the new byte goes to lane 0.
- Counters use width $clog2 of their terminal value. Bit and lane counters wrap only via explicit clear.

Decomposition:
- Package uart_pkg: rx state enum, G_UART_IWS=8 constant, thold-width function (shared with the TX wrap).
- Sub-module uart_rx: synchronizer + bit FSM. Outputs are a byte, a strobe, frame_err and busy.
- Top contains the packer, timeout and output register.

Test Plan (CLKS_PER_BIT=16, 32-bit, timeout 20):
- Serial bytes 0x11,0x22,0x33,0x44 -> one word 0x44332211, thold=0, tvalid the cycle after the 4th strobe.
- Bytes 0xA5,0x5A, then idle line -> after 320 idle cycles a word 0x00005AA5 with thold=2.
- Byte 0x7E with stop bit driven low, line held low 100 cycles -> one frame_err pulse, no byte, no further frames until the line returns high.
- 4-cycle low glitch on i_rxd -> no strobe, busy returns to 0, no output.
- tready=0 while 9 bytes arrive -> first word held stable, second word pending, 9th byte dropped with an overrun pulse. Releasing tready drains both words in order.
- Reset asserted in DATA after 2 packed bytes -> all outputs return to reset values. A following 4-byte sequence yields a clean word.
